// File: rtl/cu_pkg.sv
// Shared types for the pipelined control unit: opcodes, ALU-op and forward encodings,
// the per-stage control bundles and the ID-stage decoder.
package cu_pkg;

    localparam int REG_W  = 5;
    localparam int OP_W   = 6;
    localparam int ALUOP_BITS = 2;

    localparam logic [OP_W-1:0] OP_RTYPE   = 6'b000000;
    localparam logic [OP_W-1:0] OP_J       = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL     = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ     = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE     = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI    = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI    = 6'b001010;
    localparam logic [OP_W-1:0] OP_SPECIAL = 6'b011100;
    localparam logic [OP_W-1:0] OP_LW      = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW      = 6'b101011;

    localparam logic [ALUOP_BITS-1:0] ALU_ADD   = 2'b00;
    localparam logic [ALUOP_BITS-1:0] ALU_SUB   = 2'b01;
    localparam logic [ALUOP_BITS-1:0] ALU_FUNCT = 2'b10;
    localparam logic [ALUOP_BITS-1:0] ALU_SLT   = 2'b11;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [REG_W-1:0] REG_RA = 5'd31;

    typedef struct packed {
        logic [ALUOP_BITS-1:0] alu_op;
        logic                  alu_src;
        logic                  reg_dst;
        logic                  is_slt;
        logic                  branch;
        logic                  bne;
    } ex_ctrl_t;

    typedef struct packed {
        logic mem_rd;
        logic mem_wr;
    } mem_ctrl_t;

    typedef struct packed {
        logic             reg_write;
        logic             mem_to_reg;
        logic             jal;
        logic [REG_W-1:0] dest;
    } wb_ctrl_t;

    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } ex_stage_t;

    typedef struct packed {
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } mem_stage_t;

    // Full ID bundle; jump only steers the PC so it never enters the pipe.
    typedef struct packed {
        logic      jump;
        ex_stage_t stg;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    function automatic ctrl_t cu_decode(input logic             valid,
                                        input logic [OP_W-1:0]  opcode,
                                        input logic [REG_W-1:0] rt,
                                        input logic [REG_W-1:0] rd);
        ctrl_t c;
        c = CTRL_NOP;
        if (valid) begin
            case (opcode)
                OP_RTYPE, OP_SPECIAL: begin
                    c.stg.ex.reg_dst   = 1'b1;
                    c.stg.ex.alu_op    = ALU_FUNCT;
                    c.stg.wb.reg_write = 1'b1;
                end
                OP_LW: begin
                    c.stg.ex.alu_src    = 1'b1;
                    c.stg.ex.alu_op     = ALU_ADD;
                    c.stg.mem.mem_rd    = 1'b1;
                    c.stg.wb.mem_to_reg = 1'b1;
                    c.stg.wb.reg_write  = 1'b1;
                end
                OP_SW: begin
                    c.stg.ex.alu_src = 1'b1;
                    c.stg.mem.mem_wr = 1'b1;
                end
                OP_BEQ, OP_BNE: begin
                    c.stg.ex.branch = 1'b1;
                    c.stg.ex.alu_op = ALU_SUB;
                    c.stg.ex.bne    = (opcode == OP_BNE);
                end
                OP_ADDI: begin
                    c.stg.ex.alu_src   = 1'b1;
                    c.stg.ex.alu_op    = ALU_ADD;
                    c.stg.wb.reg_write = 1'b1;
                end
                OP_SLTI: begin
                    c.stg.ex.alu_src   = 1'b1;
                    c.stg.ex.is_slt    = 1'b1;
                    c.stg.ex.alu_op    = ALU_SLT;
                    c.stg.wb.reg_write = 1'b1;
                end
                OP_J: begin
                    c.jump = 1'b1;
                end
                OP_JAL: begin
                    c.jump             = 1'b1;
                    c.stg.wb.jal       = 1'b1;
                    c.stg.wb.reg_write = 1'b1;
                end
                default: ;
            endcase
            if (c.stg.ex.reg_dst)
                c.stg.wb.dest = rd;
            else if (c.stg.wb.jal)
                c.stg.wb.dest = REG_RA;
            else if (c != CTRL_NOP)
                c.stg.wb.dest = rt;
        end
        return c;
    endfunction

    // rs is always treated as a source; rt only for register-register forms.
    function automatic logic cu_reads_rt(input logic [OP_W-1:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
               (opcode == OP_BNE) || (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/cu_hazard_unit.sv
// Stall, flush and (with CU_FORWARD_EN) forward-select logic, all combinational
// from the current stage registers and the ID-stage inputs.
module cu_hazard_unit
    import cu_pkg::*;
(
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_reads_rt,
    input  logic             id_jump,
    input  logic             ex_mem_rd,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_branch,
    input  logic             ex_branch_taken,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] mem_dest,
`ifdef CU_FORWARD_EN
    input  logic             wb_reg_write,
    input  logic [REG_W-1:0] wb_dest,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
`else
    input  logic             ex_reg_write,
`endif
    output logic             stall_if,
    output logic             flush_ifid,
    output logic             bubble_ex
);

    function automatic logic hits(input logic             wr,
                                  input logic [REG_W-1:0] dest,
                                  input logic [REG_W-1:0] src);
        return wr && (dest != '0) && (dest == src);
    endfunction

    logic rt_used;
    logic hazard;
    logic taken;

    assign rt_used = id_valid & id_reads_rt;
    assign taken   = ex_branch & ex_branch_taken;

`ifdef CU_FORWARD_EN
    // Only a load in EX cannot be bypassed; everything else is forwarded.
    assign hazard = (id_valid && hits(ex_mem_rd, ex_dest, id_rs)) ||
                    (rt_used  && hits(ex_mem_rd, ex_dest, id_rt));

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
        if (hits(mem_reg_write, mem_dest, src))
            return FWD_MEM;
        else if (hits(wb_reg_write, wb_dest, src))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    assign fwd_a = fwd_sel(ex_rs);
    assign fwd_b = fwd_sel(ex_rt);
`else
    logic load_or_alu_ex;
    assign load_or_alu_ex = ex_reg_write | ex_mem_rd;
    assign hazard = (id_valid && (hits(load_or_alu_ex, ex_dest, id_rs) ||
                                  hits(mem_reg_write, mem_dest, id_rs))) ||
                    (rt_used  && (hits(load_or_alu_ex, ex_dest, id_rt) ||
                                  hits(mem_reg_write, mem_dest, id_rt)));
`endif

    // A taken branch squashes the ID instruction, so any stall it wanted is moot.
    assign stall_if   = hazard & ~taken;
    assign flush_ifid = taken | (id_jump & ~hazard);
    assign bubble_ex  = taken | hazard;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS control unit: ID decode plus ID/EX, EX/MEM, MEM/WB control registers.
// Define CU_FORWARD_EN to add the fwd_a/fwd_b forwarding selects.
module pipe_ctrl_unit
    import cu_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int OPCODE_W   = 6,
    parameter int ALUOP_W    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [OPCODE_W-1:0]   id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_branch_taken,
    output logic                  stall_if,
    output logic                  flush_ifid,
`ifdef CU_FORWARD_EN
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
`endif
    output logic                  id_jump,
    output logic                  id_jal,
    output logic [ALUOP_W-1:0]    ex_alu_op,
    output logic                  ex_alu_src,
    output logic                  ex_reg_dst,
    output logic                  ex_is_slt,
    output logic                  ex_branch,
    output logic                  ex_bne,
    output logic                  mem_mem_rd,
    output logic                  mem_mem_wr,
    output logic                  wb_reg_write,
    output logic                  wb_mem_to_reg,
    output logic                  wb_jal,
    output logic [REG_ADDR_W-1:0] wb_dest
);

    ctrl_t      id_ctrl;
    ex_stage_t  ex_d, ex_q;
    mem_stage_t mem_q;
    wb_ctrl_t   wb_q;
    logic       bubble_ex;

    assign id_ctrl = cu_decode(id_valid, id_opcode, id_rt, id_rd);
    assign id_jump = id_ctrl.jump;
    assign id_jal  = id_ctrl.stg.wb.jal;
    assign ex_d    = bubble_ex ? CTRL_NOP.stg : id_ctrl.stg;

`ifdef CU_FORWARD_EN
    logic [REG_W-1:0] ex_rs_d, ex_rs_q;
    logic [REG_W-1:0] ex_rt_d, ex_rt_q;

    assign ex_rs_d = bubble_ex ? '0 : id_rs;
    assign ex_rt_d = bubble_ex ? '0 : id_rt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_rs_q <= '0;
            ex_rt_q <= '0;
        end else begin
            ex_rs_q <= ex_rs_d;
            ex_rt_q <= ex_rt_d;
        end
    end
`endif

    cu_hazard_unit u_hazard (
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_reads_rt     (cu_reads_rt(id_opcode)),
        .id_jump         (id_ctrl.jump),
        .ex_mem_rd       (ex_q.mem.mem_rd),
        .ex_dest         (ex_q.wb.dest),
        .ex_branch       (ex_q.ex.branch),
        .ex_branch_taken (ex_branch_taken),
        .mem_reg_write   (mem_q.wb.reg_write),
        .mem_dest        (mem_q.wb.dest),
`ifdef CU_FORWARD_EN
        .wb_reg_write    (wb_q.reg_write),
        .wb_dest         (wb_q.dest),
        .ex_rs           (ex_rs_q),
        .ex_rt           (ex_rt_q),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
`else
        .ex_reg_write    (ex_q.wb.reg_write),
`endif
        .stall_if        (stall_if),
        .flush_ifid      (flush_ifid),
        .bubble_ex       (bubble_ex)
    );

    // EX/MEM/WB keep shifting during a stall; only ID is held upstream.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_q  <= CTRL_NOP.stg;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q      <= ex_d;
            mem_q.mem <= ex_q.mem;
            mem_q.wb  <= ex_q.wb;
            wb_q      <= mem_q.wb;
        end
    end

    assign ex_alu_op     = ex_q.ex.alu_op;
    assign ex_alu_src    = ex_q.ex.alu_src;
    assign ex_reg_dst    = ex_q.ex.reg_dst;
    assign ex_is_slt     = ex_q.ex.is_slt;
    assign ex_branch     = ex_q.ex.branch;
    assign ex_bne        = ex_q.ex.bne;
    assign mem_mem_rd    = mem_q.mem.mem_rd;
    assign mem_mem_wr    = mem_q.mem.mem_wr;
    assign wb_reg_write  = wb_q.reg_write;
    assign wb_mem_to_reg = wb_q.mem_to_reg;
    assign wb_jal        = wb_q.jal;
    assign wb_dest       = wb_q.dest;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed self-checking bench for pipe_ctrl_unit; expectations follow CU_FORWARD_EN.
module tb_pipe_ctrl_unit;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BAD  = 6'b111111;

`ifdef CU_FORWARD_EN
    localparam int FWD = 1;
`else
    localparam int FWD = 0;
`endif

    logic       clock, reset;
    logic       id_valid, ex_branch_taken;
    logic [5:0] id_opcode;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       stall_if, flush_ifid, id_jump, id_jal;
    logic [1:0] ex_alu_op;
    logic       ex_alu_src, ex_reg_dst, ex_is_slt, ex_branch, ex_bne;
    logic       mem_mem_rd, mem_mem_wr;
    logic       wb_reg_write, wb_mem_to_reg, wb_jal;
    logic [4:0] wb_dest;
`ifdef CU_FORWARD_EN
    logic [1:0] fwd_a, fwd_b;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    pipe_ctrl_unit dut (
        .clock           (clock),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_opcode       (id_opcode),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .ex_branch_taken (ex_branch_taken),
        .stall_if        (stall_if),
        .flush_ifid      (flush_ifid),
`ifdef CU_FORWARD_EN
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
`endif
        .id_jump         (id_jump),
        .id_jal          (id_jal),
        .ex_alu_op       (ex_alu_op),
        .ex_alu_src      (ex_alu_src),
        .ex_reg_dst      (ex_reg_dst),
        .ex_is_slt       (ex_is_slt),
        .ex_branch       (ex_branch),
        .ex_bne          (ex_bne),
        .mem_mem_rd      (mem_mem_rd),
        .mem_mem_wr      (mem_mem_wr),
        .wb_reg_write    (wb_reg_write),
        .wb_mem_to_reg   (wb_mem_to_reg),
        .wb_jal          (wb_jal),
        .wb_dest         (wb_dest)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [5:0] op,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_valid  = v;
        id_opcode = op;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        ex_branch_taken = 1'b0;
        set_id(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
        tick; tick; #1;
        chk("reset_stall",   32'(stall_if), 0);
        chk("reset_flush",   32'(flush_ifid), 0);
        chk("reset_alu_src", 32'(ex_alu_src), 0);
        chk("reset_wb_rw",   32'(wb_reg_write), 0);
        chk("reset_mem_rd",  32'(mem_mem_rd), 0);
`ifdef CU_FORWARD_EN
        chk("reset_fwd_a",   32'(fwd_a), 0);
`endif

        // stream, then reset while a load-use stall is active
        reset = 1'b0;
        set_id(1'b1, OP_ADDI, 5'd1, 5'd5, 5'd0);
        tick; set_id(1'b1, OP_LW, 5'd2, 5'd8, 5'd0); #1;
        chk("addi_ex_alu_src", 32'(ex_alu_src), 1);
        tick; set_id(1'b1, OP_R, 5'd8, 5'd1, 5'd9); #1;
        chk("pre_reset_stall", 32'(stall_if), 1);
        reset = 1'b1; #1;
        chk("mid_reset_stall",   32'(stall_if), 0);
        chk("mid_reset_alu_src", 32'(ex_alu_src), 0);
        set_id(1'b1, OP_LW, 5'd2, 5'd8, 5'd0);
        reset = 1'b0; #1;
        chk("rel_stall",   32'(stall_if), 0);
        chk("rel_flush",   32'(flush_ifid), 0);
        chk("rel_alu_src", 32'(ex_alu_src), 0);
        chk("rel_alu_op",  32'(ex_alu_op), 0);
        chk("rel_mem_rd",  32'(mem_mem_rd), 0);
        chk("rel_wb_rw",   32'(wb_reg_write), 0);

        // lw $8 ; add $9,$8,$1
        tick; set_id(1'b1, OP_R, 5'd8, 5'd1, 5'd9); #1;
        chk("lw_ex_alu_src", 32'(ex_alu_src), 1);
        chk("lw_ex_alu_op",  32'(ex_alu_op), 0);
        chk("lw_ex_reg_dst", 32'(ex_reg_dst), 0);
        chk("lu_stall_1",    32'(stall_if), 1);
        chk("lu_flush_1",    32'(flush_ifid), 0);
        tick; #1;
        chk("lu_bubble_alu_src", 32'(ex_alu_src), 0);
        chk("lu_mem_rd",         32'(mem_mem_rd), 1);
        chk("lu_stall_2",        32'(stall_if), (FWD != 0) ? 0 : 1);
`ifndef CU_FORWARD_EN
        tick; #1;
        chk("lu_stall_3",    32'(stall_if), 0);
        chk("lu_bubble2",    32'(ex_reg_dst), 0);
        chk("lw_wb_m2r",     32'(wb_mem_to_reg), 1);
        chk("lw_wb_dest",    32'(wb_dest), 8);
        tick; #1;
        chk("add_ex_reg_dst", 32'(ex_reg_dst), 1);
`else
        tick; #1;
        chk("add_ex_reg_dst", 32'(ex_reg_dst), 1);
        chk("add_fwd_a",      32'(fwd_a), 1);
        chk("add_fwd_b",      32'(fwd_b), 0);
        chk("lw_wb_m2r",      32'(wb_mem_to_reg), 1);
        chk("lw_wb_dest",     32'(wb_dest), 8);
`endif

        // lw $10 ; beq $1,$2 taken while add reading $10 sits in ID
        set_id(1'b1, OP_LW, 5'd3, 5'd10, 5'd0); #1;
        chk("lw10_id_stall", 32'(stall_if), 0);
        tick; set_id(1'b1, OP_BEQ, 5'd1, 5'd2, 5'd0); #1;
        chk("beq_id_stall", 32'(stall_if), 0);
        tick; set_id(1'b1, OP_R, 5'd10, 5'd4, 5'd11); ex_branch_taken = 1'b1; #1;
        chk("br_flush",     32'(flush_ifid), 1);
        chk("br_stall",     32'(stall_if), 0);
        chk("br_ex_branch", 32'(ex_branch), 1);
        chk("br_ex_alu_op", 32'(ex_alu_op), 1);
        chk("br_ex_bne",    32'(ex_bne), 0);

        // flushed add becomes a bubble; jal enters ID
        tick; ex_branch_taken = 1'b0; set_id(1'b1, OP_JAL, 5'd0, 5'd7, 5'd0); #1;
        chk("br_bubble_reg_dst", 32'(ex_reg_dst), 0);
        chk("br_bubble_branch",  32'(ex_branch), 0);
        chk("jal_id_jump",       32'(id_jump), 1);
        chk("jal_id_jal",        32'(id_jal), 1);
        chk("jal_flush",         32'(flush_ifid), 1);
        chk("jal_stall",         32'(stall_if), 0);

        // add $0,$1,$2 ; consumer of $0
        tick; set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd0); #1;
        chk("add0_flush", 32'(flush_ifid), 0);
        tick; set_id(1'b1, OP_R, 5'd0, 5'd0, 5'd3); #1;
        chk("zero_stall", 32'(stall_if), 0);
        tick; set_id(1'b1, OP_ADDI, 5'd1, 5'd6, 5'd0); #1;
        chk("jal_wb_rw",       32'(wb_reg_write), 1);
        chk("jal_wb_jal",      32'(wb_jal), 1);
        chk("jal_wb_dest",     32'(wb_dest), 31);
        chk("zero_ex_reg_dst", 32'(ex_reg_dst), 1);
`ifdef CU_FORWARD_EN
        chk("zero_fwd_a", 32'(fwd_a), 0);
        chk("zero_fwd_b", 32'(fwd_b), 0);
`endif

        // addi $6 ; R-type reading $6 through rt
        tick; set_id(1'b1, OP_R, 5'd1, 5'd6, 5'd7); #1;
        chk("raw_stall_1", 32'(stall_if), (FWD != 0) ? 0 : 1);
`ifndef CU_FORWARD_EN
        tick; #1;
        chk("raw_stall_2", 32'(stall_if), 1);
        tick; #1;
        chk("raw_stall_3", 32'(stall_if), 0);
        tick; #1;
        chk("raw_ex_reg_dst", 32'(ex_reg_dst), 1);
`else
        tick; #1;
        chk("raw_ex_reg_dst", 32'(ex_reg_dst), 1);
        chk("raw_fwd_b",      32'(fwd_b), 2);
        chk("raw_fwd_a",      32'(fwd_a), 0);
`endif

        // slti ; bad opcode ; sw ; bne
        set_id(1'b1, OP_SLTI, 5'd1, 5'd4, 5'd0);
        tick; set_id(1'b1, OP_BAD, 5'd1, 5'd9, 5'd9); #1;
        chk("slti_is_slt",  32'(ex_is_slt), 1);
        chk("slti_alu_op",  32'(ex_alu_op), 3);
        chk("slti_alu_src", 32'(ex_alu_src), 1);
        chk("bad_id_jump",  32'(id_jump), 0);
        chk("bad_flush",    32'(flush_ifid), 0);
        chk("bad_stall",    32'(stall_if), 0);
        tick; set_id(1'b1, OP_SW, 5'd1, 5'd2, 5'd0); #1;
        chk("bad_ex_alu_src", 32'(ex_alu_src), 0);
        chk("bad_ex_reg_dst", 32'(ex_reg_dst), 0);
        chk("bad_ex_is_slt",  32'(ex_is_slt), 0);
        tick; set_id(1'b1, OP_BNE, 5'd1, 5'd2, 5'd0); #1;
        chk("slti_wb_rw",     32'(wb_reg_write), 1);
        chk("slti_wb_dest",   32'(wb_dest), 4);
        chk("sw_ex_alu_src",  32'(ex_alu_src), 1);
        tick; set_id(1'b0, OP_R, 5'd0, 5'd0, 5'd0); #1;
        chk("bad_wb_rw",    32'(wb_reg_write), 0);
        chk("bad_wb_dest",  32'(wb_dest), 0);
        chk("sw_mem_wr",    32'(mem_mem_wr), 1);
        chk("bne_ex_bne",   32'(ex_bne), 1);
        chk("bne_ex_alu_op", 32'(ex_alu_op), 1);
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
